frame_writer: RTL and testbench

//  Upstream feeder for the RAM-based fftshift stage. Accepts a valid/ready sample stream,

---
 rtl/frame_writer.sv | 101 ++++++++++
 tb/tb_frame_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// Frame writer for the ping-pong fftshift RAM: cuts a valid/ready sample stream into
// frames, writes each frame into one bank and tracks which banks hold complete frames.
module frame_writer #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   cfg_len,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          frame_done,
  output logic          frame_bank,
  output logic [AW:0]   frame_len,
  output logic          rd_bank,
  output logic [1:0]    pending,
  output logic          rel_err,
  input  logic          rd_release
);

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

  state_t        state, state_d;
  logic [AW:0]   len;
  logic [AW-1:0] idx;
  logic          wb;
  logic          cfg_ok, accept, eof, rel_ok;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  assign accept = s_valid & s_ready;
  // s_last arriving on the final index is still a single end of frame.
  assign eof    = accept & (s_last | ({1'b0, idx} == len - 1'b1));
  assign rel_ok = rd_release & (pending != 2'd0);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    s_ready = 1'b0;
    case (state)
      IDLE: if (cfg_ok) state_d = (pending < 2'd2) ? FILL : WAIT;
      FILL: begin
        s_ready = 1'b1;
        if (eof) state_d = IDLE;
      end
      WAIT: if (pending < 2'd2) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      idx        <= '0;
      wb         <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_bank <= 1'b0;
      frame_len  <= '0;
      rd_bank    <= 1'b0;
      pending    <= 2'd0;
      rel_err    <= 1'b0;
    end else begin
      wr_en      <= accept;
      frame_done <= eof;
      if (accept) begin
        wr_addr <= {wb, idx};
        wr_data <= s_data;
      end
      if (state == IDLE && cfg_ok) len <= cfg_len;
      if (eof) begin
        frame_bank <= wb;
        frame_len  <= {1'b0, idx} + 1'b1;
        wb         <= ~wb;
        idx        <= '0;
      end else if (accept) begin
        idx <= idx + 1'b1;
      end
      // A release and a frame completion on the same edge cancel out.
      pending <= pending + {1'b0, eof} - {1'b0, rel_ok};
      if (rel_ok) rd_bank <= ~rd_bank;
      if (rd_release && pending == 2'd0) rel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: a bank/frame-count model is compared every cycle,
// and per-test literal expectations pin the model.
module tb_frame_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] cfg_len;
  logic       s_valid, s_last, s_ready;
  logic [7:0] s_data;
  logic       wr_en, frame_done, frame_bank, rd_bank, rel_err, rd_release;
  logic [8:0] wr_addr, frame_len;
  logic [7:0] wr_data;
  logic [1:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  frame_writer #(.DW(8), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_bank(frame_bank), .frame_len(frame_len),
    .rd_bank(rd_bank), .pending(pending), .rel_err(rel_err), .rd_release(rd_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for a frame length, 1 = taking samples, 2 = both banks full.
  int m_phase, m_len, m_idx, m_frames, m_rels, m_pend, m_addr, m_data, m_flen;
  bit m_ready, m_wr_en, m_done, m_fbank, m_rel_err;
  int log_addr[$], log_data[$], log_fbank[$], log_flen[$];

  always @(negedge clk) begin
    bit acc, eof, rel_ok;
    if (!rst_n) begin
      m_phase = 0; m_len = 0; m_idx = 0; m_frames = 0; m_rels = 0; m_pend = 0;
      m_addr = 0; m_data = 0; m_flen = 0;
      m_ready = 0; m_wr_en = 0; m_done = 0; m_fbank = 0; m_rel_err = 0;
    end
    check("s_ready", s_ready, m_ready);
    check("wr_en", wr_en, m_wr_en);
    if (m_wr_en) begin
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
    end
    check("frame_done", frame_done, m_done);
    check("frame_bank", frame_bank, m_fbank);
    check("frame_len", frame_len, m_flen);
    check("rd_bank", rd_bank, m_rels % 2);
    check("pending", pending, m_pend);
    check("rel_err", rel_err, m_rel_err);
    if (rst_n) begin
      if (wr_en) begin log_addr.push_back(int'(wr_addr)); log_data.push_back(int'(wr_data)); end
      if (frame_done) begin log_fbank.push_back(int'(frame_bank)); log_flen.push_back(int'(frame_len)); end
      acc = m_ready && s_valid;
      eof = acc && ((m_idx == m_len - 1) || s_last);
      m_wr_en = acc;
      if (acc) begin
        m_addr = (m_frames % 2) * 256 + m_idx;
        m_data = int'(s_data);
      end
      m_done = eof;
      if (eof) begin
        m_fbank = (m_frames % 2) == 1;
        m_flen  = m_idx + 1;
      end
      rel_ok = rd_release && m_pend > 0;
      if (rd_release && m_pend == 0) m_rel_err = 1;
      case (m_phase)
        0: if (cfg_len >= 1 && cfg_len <= 256) begin
             m_len = int'(cfg_len);
             m_phase = (m_pend < 2) ? 1 : 2;
           end
        1: if (eof) begin m_phase = 0; m_idx = 0; end
           else if (acc) m_idx++;
        default: if (m_pend < 2) m_phase = 1;
      endcase
      m_frames += int'(eof);
      m_rels   += int'(rel_ok);
      m_pend    = m_pend + int'(eof) - int'(rel_ok);
      m_ready   = (m_phase == 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_fbank.delete(); log_flen.delete();
  endtask

  task automatic pulse_release();
    rd_release = 1'b1; tick(1); rd_release = 1'b0;
  endtask

  // Sends n samples base, base+1, ...; s_last on sample number last_at (1-based, 0 = none).
  // The next frame length (and optionally a release) is driven with the final sample.
  task automatic send_frame(input int n, input int base, input int last_at,
                            input int next_cfg, input bit rel_last);
    for (int i = 0; i < n; i++) begin
      bit acc = 0;
      int guard = 0;
      s_valid = 1'b1;
      s_data  = 8'(base + i);
      s_last  = (i + 1 == last_at);
      if (i == n - 1) begin
        cfg_len    = 9'(next_cfg);
        rd_release = rel_last;
      end
      while (!acc) begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 1000) begin
          n_tests++; n_fail++;
          $display("FAIL accept_timeout: sample %0d not accepted within %0d cycles", i, guard);
          s_valid = 1'b0; s_last = 1'b0; rd_release = 1'b0;
          return;
        end
      end
      rd_release = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_len = 9'd9; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    rd_release = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // T1: one 9-sample frame into bank 0
    clear_logs();
    send_frame(9, 1, 0, 9, 0);
    tick(3);
    check("t1_nwrites", log_addr.size(), 9);
    for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
      check("t1_addr", log_addr[i], i);
      check("t1_data", log_data[i], i + 1);
    end
    check("t1_ndone", log_fbank.size(), 1);
    if (log_fbank.size() > 0) begin
      check("t1_fbank", log_fbank[0], 0);
      check("t1_flen", log_flen[0], 9);
    end
    check("t1_pending", pending, 1);

    // T2: second frame into bank 1, then both banks full
    clear_logs();
    send_frame(9, 10, 0, 16, 0);
    tick(3);
    check("t2_nwrites", log_addr.size(), 9);
    if (log_addr.size() == 9) begin
      check("t2_first_addr", log_addr[0], 256);
      check("t2_last_addr", log_addr[8], 264);
      check("t2_last_data", log_data[8], 18);
    end
    check("t2_ready_blocked", s_ready, 0);
    check("t2_pending_full", pending, 2);
    pulse_release();
    check("t2_rd_bank", rd_bank, 1);
    check("t2_pending", pending, 1);
    check("t2_ready_late", s_ready, 0);
    tick(1);
    check("t2_ready_rise", s_ready, 1);

    // T3: cfg_len 16 cut short by s_last on sample 5
    clear_logs();
    send_frame(5, 20, 5, 16, 0);
    tick(2);
    check("t3_nwrites", log_addr.size(), 5);
    if (log_addr.size() == 5) check("t3_last_addr", log_addr[4], 4);
    if (log_flen.size() > 0) begin
      check("t3_flen", log_flen[0], 5);
      check("t3_fbank", log_fbank[0], 0);
    end
    check("t3_pending", pending, 2);
    pulse_release(); tick(2);

    // s_last on the very first sample: 1-sample frame in bank 1
    clear_logs();
    send_frame(1, 99, 1, 256, 0);
    tick(2);
    check("t3b_ndone", log_flen.size(), 1);
    if (log_flen.size() > 0) check("t3b_flen", log_flen[0], 1);
    if (log_addr.size() > 0) check("t3b_addr", log_addr[0], 256);
    pulse_release(); tick(2);
    pulse_release(); tick(2);
    check("t3b_pending", pending, 0);

    // T4: full-depth frame, index must not spill into the bank bit
    clear_logs();
    send_frame(256, 0, 0, 4, 0);
    tick(2);
    check("t4_nwrites", log_addr.size(), 256);
    if (log_addr.size() == 256) begin
      check("t4_last_addr", log_addr[255], 255);
      check("t4_last_data", log_data[255], 255);
    end
    if (log_flen.size() > 0) check("t4_flen", log_flen[0], 256);
    check("t4_pending", pending, 1);

    // T5: release on the same edge as the frame completion, then an illegal release
    clear_logs();
    send_frame(4, 50, 0, 8, 1);
    check("t5_done_now", frame_done, 1);
    check("t5_pending_same", pending, 1);
    check("t5_rd_bank", rd_bank, 1);
    tick(1);
    if (log_addr.size() > 0) check("t5_next_start", log_addr[0], 256);
    pulse_release();
    check("t5_pending_zero", pending, 0);
    check("t5_rel_err_clear", rel_err, 0);
    pulse_release();
    check("t5_rel_err", rel_err, 1);
    check("t5_pending_kept", pending, 0);
    check("t5_rd_bank_kept", rd_bank, 0);
    check("t5_ready_kept", s_ready, 1);

    // T6: reset after 4 accepted samples discards the partial frame
    send_frame(4, 60, 0, 3, 0);
    rst_n = 1'b0;
    tick(2);
    check("t6_rel_err_reset", rel_err, 0);
    rst_n = 1'b1;
    clear_logs();
    send_frame(3, 70, 0, 0, 0);
    tick(3);
    check("t6_ndone", log_fbank.size(), 1);
    if (log_fbank.size() > 0) begin
      check("t6_fbank", log_fbank[0], 0);
      check("t6_flen", log_flen[0], 3);
    end
    check("t6_nwrites", log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check("t6_addr", log_addr[i], i);
      check("t6_data", log_data[i], 70 + i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
